// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline sequencer: boot mode encoding and
// the execute/writeback stage indices derived from the pipeline depth.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'd0,
    MODE_LOAD = 2'd1,
    MODE_RUN  = 2'd2,
    MODE_HALT = 2'd3
  } mode_e;

  // Execute is always the second-to-last stage.
  function automatic int ex_idx(input int nstage);
    return nstage - 2;
  endfunction

  // Writeback is always the last stage.
  function automatic int wb_idx(input int nstage);
    return nstage - 1;
  endfunction

endpackage

// File: rtl/pipe_lat_counter.sv
// Variable-latency execute counter: restarts when a valid instruction
// loads into EX, counts up to ex_wait, and signals completion unless the
// UART is still busy.
module pipe_lat_counter #(
  parameter int LAT_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ld,
  input  logic             ex_vld,
  input  logic [LAT_W-1:0] ex_wait,
  input  logic             ex_uart_busy,
  output logic             e_start,
  output logic             ex_done
);

  logic [LAT_W-1:0] lat_cnt;

  // Counter restart on EX load, otherwise saturating count up to ex_wait.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      lat_cnt <= '0;
      e_start <= 1'b0;
    end else begin
      e_start <= ld;
      if (ld)
        lat_cnt <= '0;
      else if (ex_vld && (lat_cnt < ex_wait))
        lat_cnt <= lat_cnt + LAT_W'(1);
    end
  end

  assign ex_done = ex_vld && (lat_cnt == ex_wait) && !ex_uart_busy;

endmodule

// File: rtl/pipe_ctrl.sv
// In-order pipeline sequencer: boot mode FSM, per-stage valid/update/flush
// control, PC, decode-hazard stalls, execute redirects and stop/halt.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGE = 4,
  parameter int PC_W   = 32,
  parameter int LAT_W  = 5,
  parameter int PC_INC = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              aa_recieved,
  input  logic              load_done,
  input  logic              aa_sent,
  input  logic              d_hazard,
  input  logic              d_stop,
  input  logic              d_jump,
  input  logic [PC_W-1:0]   d_npc,
  input  logic [LAT_W-1:0]  ex_wait,
  input  logic              ex_uart_busy,
  input  logic              ex_redirect,
  input  logic [PC_W-1:0]   ex_target,
  output logic [1:0]        mode,
  output logic [PC_W-1:0]   pc,
  output logic [NSTAGE-2:0] upd,
  output logic [NSTAGE-1:0] vld,
  output logic [NSTAGE-1:0] flush,
  output logic              e_start,
  output logic              ex_done,
  output logic              halted
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]       cyc_cnt,
  output logic [31:0]       ret_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int EX = ex_idx(NSTAGE);
  localparam int WB = wb_idx(NSTAGE);

  mode_e st, st_n;
  logic  run;
  logic  stop_seen, stop_seen_n;
  logic  redir, jump, stop_adv, halt_now, ld_ex;
  logic [NSTAGE-1:0] stall, kill, vld_n;
  logic [NSTAGE-1:2] stop_tag, tag_n, tag_sh;
  logic [PC_W-1:0]   pc_n;

  assign run    = (st == MODE_RUN);
  assign mode   = st;
  assign halted = (st == MODE_HALT);
  assign flush  = kill;
  // Stop tags enter at stage 2 from the decode-stage d_stop flag.
  assign tag_sh = {stop_tag[NSTAGE-2:2], d_stop};

  // Mode state register.
  always_ff @(posedge clk) begin
    if (!rstn) st <= MODE_IDLE;
    else       st <= st_n;
  end

  // Mode next-state: boot handshake, run, sticky halt.
  always_comb begin
    st_n = st;
    case (st)
      MODE_IDLE: if (aa_recieved)          st_n = MODE_LOAD;
      MODE_LOAD: if (load_done && aa_sent) st_n = MODE_RUN;
      MODE_RUN:  if (halt_now)             st_n = MODE_HALT;
      default:                             st_n = MODE_HALT;
    endcase
  end

  // Backward stall chain, redirect/jump kills and advance-derived events.
  always_comb begin
    stall = '0;
    kill  = '0;
    stall[EX] = vld[EX] && !ex_done;
    for (int i = EX - 1; i >= 0; i--) begin
      stall[i] = vld[i+1] && stall[i+1];
      if (i == 1) stall[i] = stall[i] | (vld[1] && d_hazard);
    end
    redir = run && ex_done && ex_redirect;
    jump  = run && vld[1] && d_jump && !stall[1] && !redir;
    for (int i = 0; i < EX; i++) kill[i] = redir;
    kill[0]  = kill[0] | jump;
    stop_adv = run && vld[1] && d_stop && !stall[1] && !kill[1];
    halt_now = run && vld[WB] && stop_tag[WB];
    ld_ex    = run && !halt_now && !stall[EX] && vld[EX-1] &&
               !stall[EX-1] && !kill[EX-1];
    for (int i = 0; i < NSTAGE - 1; i++) upd[i] = run && !stall[i+1];
  end

  // Next valid/tag/PC values while running.
  always_comb begin
    vld_n = '0;
    tag_n = '0;
    // Fetch restarts on redirect, freezes once a stop has left decode.
    if (redir)                       vld_n[0] = 1'b1;
    else if (stop_seen || stop_adv)  vld_n[0] = 1'b0;
    else if (stall[0])               vld_n[0] = vld[0];
    else                             vld_n[0] = 1'b1;
    // Held stages keep their slot (unless killed); free ones take from below,
    // and the instruction fetched behind a stop is never let into decode.
    for (int i = 0; i < NSTAGE - 1; i++) begin
      if (stall[i+1]) vld_n[i+1] = vld[i+1] && !kill[i+1];
      else            vld_n[i+1] = vld[i] && !stall[i] && !kill[i] &&
                                   !((i == 0) && stop_adv);
    end
    for (int i = 2; i < NSTAGE; i++)
      tag_n[i] = stall[i] ? stop_tag[i] : tag_sh[i];
    if (redir)                                 pc_n = ex_target;
    else if (stop_seen || stop_adv || stall[0]) pc_n = pc;
    else if (jump)                             pc_n = d_npc;
    else                                       pc_n = pc + PC_W'(PC_INC);
    // Any redirect while a stop is pending necessarily flushes that stop.
    if (redir)         stop_seen_n = 1'b0;
    else if (stop_adv) stop_seen_n = 1'b1;
    else               stop_seen_n = stop_seen;
  end

  // Pipeline state: valids, stop tags, PC and fetch-freeze flag.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc        <= '0;
      vld       <= '0;
      stop_tag  <= '0;
      stop_seen <= 1'b0;
    end else if (st == MODE_LOAD && st_n == MODE_RUN) begin
      pc        <= '0;
      vld       <= NSTAGE'(1);
      stop_tag  <= '0;
      stop_seen <= 1'b0;
    end else if (run) begin
      if (halt_now) begin
        vld <= '0;
      end else begin
        vld       <= vld_n;
        stop_tag  <= tag_n;
        pc        <= pc_n;
        stop_seen <= stop_seen_n;
      end
    end
  end

  pipe_lat_counter #(.LAT_W(LAT_W)) u_lat (
    .clk          (clk),
    .rstn         (rstn),
    .ld           (ld_ex),
    .ex_vld       (vld[EX]),
    .ex_wait      (ex_wait),
    .ex_uart_busy (ex_uart_busy),
    .e_start      (e_start),
    .ex_done      (ex_done)
  );

`ifdef PIPE_CTRL_PERF_EN
  // Wrapping run-cycle, retire and fetch-stall counters.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cyc_cnt   <= '0;
      ret_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (run)             cyc_cnt   <= cyc_cnt + 32'd1;
      if (run && vld[WB])  ret_cnt   <= ret_cnt + 32'd1;
      if (run && stall[0]) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (NSTAGE=4): a cycle table covering boot,
// streaming, execute latency, hazard, redirect and jump, plus hand-written
// stop/halt, stop-flush and mid-run reset sequences.
module tb_pipe_ctrl;

  logic        clk, rstn;
  logic        aa_recieved, load_done, aa_sent, d_hazard, d_stop, d_jump;
  logic [31:0] d_npc, ex_target;
  logic [4:0]  ex_wait;
  logic        ex_uart_busy, ex_redirect;
  logic [1:0]  mode;
  logic [31:0] pc;
  logic [2:0]  upd;
  logic [3:0]  vld, flush;
  logic        e_start, ex_done, halted;

  int passed = 0;
  int total  = 0;

  pipe_ctrl #(.NSTAGE(4), .PC_W(32), .LAT_W(5), .PC_INC(1)) dut (
    .clk(clk), .rstn(rstn), .aa_recieved(aa_recieved), .load_done(load_done),
    .aa_sent(aa_sent), .d_hazard(d_hazard), .d_stop(d_stop), .d_jump(d_jump),
    .d_npc(d_npc), .ex_wait(ex_wait), .ex_uart_busy(ex_uart_busy),
    .ex_redirect(ex_redirect), .ex_target(ex_target), .mode(mode), .pc(pc),
    .upd(upd), .vld(vld), .flush(flush), .e_start(e_start), .ex_done(ex_done),
    .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl = {aa_recieved, load_done, aa_sent, d_hazard, d_stop, d_jump, busy, redirect}
  typedef struct {
    logic [7:0]  ctl;
    logic [31:0] npc;
    logic [4:0]  wt;
    logic [31:0] tgt;
    logic [1:0]  e_mode;
    logic [31:0] e_pc;
    logic [3:0]  e_vld;
    logic [2:0]  e_upd;
    logic [3:0]  e_flush;
    logic        e_es, e_done, e_halt;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic [7:0] ctl, input logic [31:0] npc,
                     input logic [4:0] wt, input logic [31:0] tgt,
                     input logic [1:0] m, input logic [31:0] p,
                     input logic [3:0] v, input logic [2:0] u,
                     input logic [3:0] f, input logic es, input logic dn,
                     input logic h);
    vec_t r;
    r.ctl = ctl; r.npc = npc; r.wt = wt; r.tgt = tgt;
    r.e_mode = m; r.e_pc = p; r.e_vld = v; r.e_upd = u; r.e_flush = f;
    r.e_es = es; r.e_done = dn; r.e_halt = h;
    tv.push_back(r);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
  endtask

  task automatic clr();
    {aa_recieved, load_done, aa_sent, d_hazard, d_stop, d_jump} = '0;
    {ex_uart_busy, ex_redirect} = '0;
    d_npc = '0; ex_target = '0; ex_wait = '0;
  endtask

  // Advance to the next negedge with all data inputs idle.
  task automatic nxt();
    @(negedge clk);
    clr();
  endtask

  // Reset, boot handshake; returns at the negedge of the first RUN cycle.
  task automatic boot();
    nxt(); rstn = 1'b0;
    nxt(); rstn = 1'b1; aa_recieved = 1'b1;
    nxt(); load_done = 1'b1; aa_sent = 1'b1;
    nxt();
  endtask

  initial begin
    rstn = 1'b0;
    clr();
    // Boot handshake.
    add(8'b1000_0000, 0, 0, 0, 2'd0, 32'd0, 4'b0000, 3'b000, 4'b0000, 0, 0, 0);
    add(8'b0000_0000, 0, 0, 0, 2'd1, 32'd0, 4'b0000, 3'b000, 4'b0000, 0, 0, 0);
    add(8'b0110_0000, 0, 0, 0, 2'd1, 32'd0, 4'b0000, 3'b000, 4'b0000, 0, 0, 0);
    // Pipeline fill, single-cycle execute.
    add(8'b0000_0000, 0, 0, 0, 2'd2, 32'd0, 4'b0001, 3'b111, 4'b0000, 0, 0, 0);
    add(8'b0000_0000, 0, 0, 0, 2'd2, 32'd1, 4'b0011, 3'b111, 4'b0000, 0, 0, 0);
    add(8'b0000_0000, 0, 0, 0, 2'd2, 32'd2, 4'b0111, 3'b111, 4'b0000, 1, 1, 0);
    add(8'b0000_0000, 0, 0, 0, 2'd2, 32'd3, 4'b1111, 3'b111, 4'b0000, 1, 1, 0);
    // pc2 in EX with ex_wait=3, then UART busy for two more cycles.
    add(8'b0000_0000, 0, 3, 0, 2'd2, 32'd4, 4'b1111, 3'b100, 4'b0000, 1, 0, 0);
    add(8'b0000_0000, 0, 3, 0, 2'd2, 32'd4, 4'b0111, 3'b100, 4'b0000, 0, 0, 0);
    add(8'b0000_0000, 0, 3, 0, 2'd2, 32'd4, 4'b0111, 3'b100, 4'b0000, 0, 0, 0);
    add(8'b0000_0010, 0, 3, 0, 2'd2, 32'd4, 4'b0111, 3'b100, 4'b0000, 0, 0, 0);
    add(8'b0000_0010, 0, 3, 0, 2'd2, 32'd4, 4'b0111, 3'b100, 4'b0000, 0, 0, 0);
    add(8'b0000_0000, 0, 3, 0, 2'd2, 32'd4, 4'b0111, 3'b111, 4'b0000, 0, 1, 0);
    add(8'b0000_0000, 0, 0, 0, 2'd2, 32'd5, 4'b1111, 3'b111, 4'b0000, 1, 1, 0);
    // Decode hazard for two cycles.
    add(8'b0001_0000, 0, 0, 0, 2'd2, 32'd6, 4'b1111, 3'b110, 4'b0000, 1, 1, 0);
    add(8'b0001_0000, 0, 0, 0, 2'd2, 32'd6, 4'b1011, 3'b110, 4'b0000, 0, 0, 0);
    add(8'b0000_0000, 0, 0, 0, 2'd2, 32'd6, 4'b0011, 3'b111, 4'b0000, 0, 0, 0);
    add(8'b0000_0000, 0, 0, 0, 2'd2, 32'd7, 4'b0111, 3'b111, 4'b0000, 1, 1, 0);
    // Redirect to 0x40 with a competing d_jump to 0x99.
    add(8'b0000_0101, 32'h99, 0, 32'h40, 2'd2, 32'd8, 4'b1111, 3'b111, 4'b0011, 1, 1, 0);
    add(8'b0000_0000, 0, 0, 0, 2'd2, 32'h40, 4'b1001, 3'b111, 4'b0000, 0, 0, 0);
    // Plain decode jump to 0x80.
    add(8'b0000_0100, 32'h80, 0, 0, 2'd2, 32'h41, 4'b0011, 3'b111, 4'b0001, 0, 0, 0);
    add(8'b0000_0000, 0, 0, 0, 2'd2, 32'h80, 4'b0101, 3'b111, 4'b0000, 1, 1, 0);

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_vld", 32'(vld), 32'd0);
    chk("rst_upd", 32'(upd), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_estart", 32'(e_start), 32'd0);
    chk("rst_exdone", 32'(ex_done), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    rstn = 1'b1;

    for (int k = 0; k < tv.size(); k++) begin
      @(negedge clk);
      {aa_recieved, load_done, aa_sent, d_hazard, d_stop, d_jump,
       ex_uart_busy, ex_redirect} = tv[k].ctl;
      d_npc = tv[k].npc; ex_wait = tv[k].wt; ex_target = tv[k].tgt;
      #1;
      chk($sformatf("v%0d_mode", k), 32'(mode), 32'(tv[k].e_mode));
      chk($sformatf("v%0d_pc", k), pc, tv[k].e_pc);
      chk($sformatf("v%0d_vld", k), 32'(vld), 32'(tv[k].e_vld));
      chk($sformatf("v%0d_upd", k), 32'(upd), 32'(tv[k].e_upd));
      chk($sformatf("v%0d_flush", k), 32'(flush), 32'(tv[k].e_flush));
      chk($sformatf("v%0d_estart", k), 32'(e_start), 32'(tv[k].e_es));
      chk($sformatf("v%0d_exdone", k), 32'(ex_done), 32'(tv[k].e_done));
      chk($sformatf("v%0d_halted", k), 32'(halted), 32'(tv[k].e_halt));
    end

    // Stop at pc5: fetch freezes at pc6, stop retires, halt is sticky.
    boot();
    #1;
    chk("stop_run_pc0", pc, 32'd0);
    repeat (6) nxt();
    d_stop = 1'b1;
    #1;
    chk("stop_dec_pc", pc, 32'd6);
    chk("stop_dec_vld", 32'(vld), 32'hF);
    nxt(); #1;
    chk("stop_frz_pc", pc, 32'd6);
    chk("stop_frz_vld", 32'(vld), 32'b1100);
    nxt(); #1;
    chk("stop_wb_vld", 32'(vld), 32'b1000);
    chk("stop_wb_mode", 32'(mode), 32'd2);
    chk("stop_wb_halted", 32'(halted), 32'd0);
    nxt(); #1;
    chk("halt_mode", 32'(mode), 32'd3);
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_vld", 32'(vld), 32'd0);
    chk("halt_upd", 32'(upd), 32'd0);
    chk("halt_pc", pc, 32'd6);
    aa_recieved = 1'b1; load_done = 1'b1; aa_sent = 1'b1;
    nxt(); #1;
    chk("halt_sticky", 32'(mode), 32'd3);

    // Redirect in the cycle the stop sits in decode flushes it.
    boot();
    repeat (6) nxt();
    d_stop = 1'b1; ex_redirect = 1'b1; ex_target = 32'h20;
    #1;
    chk("sflush_exdone", 32'(ex_done), 32'd1);
    chk("sflush_flush", 32'(flush), 32'b0011);
    nxt(); #1;
    chk("sflush_pc", pc, 32'h20);
    chk("sflush_vld", 32'(vld), 32'b1001);
    nxt(); #1;
    chk("sflush_pc1", pc, 32'h21);
    chk("sflush_vld1", 32'(vld), 32'b0011);
    repeat (4) nxt();
    #1;
    chk("sflush_run_mode", 32'(mode), 32'd2);
    chk("sflush_run_pc", pc, 32'h25);
    chk("sflush_run_vld", 32'(vld), 32'hF);

    // Reset mid-run aborts in one cycle.
    nxt(); rstn = 1'b0;
    nxt(); rstn = 1'b1;
    #1;
    chk("mrst_mode", 32'(mode), 32'd0);
    chk("mrst_pc", pc, 32'd0);
    chk("mrst_vld", 32'(vld), 32'd0);
    chk("mrst_upd", 32'(upd), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Parametrised in-order pipeline sequencer for the core. It runs the boot mode FSM (idle, load, run, halt). It generates per-stage valid, update and flush controls for an NSTAGE-deep pipeline, so fetch/decode/execute overlap instead of running one instruction at a time. It owns the PC, the variable-latency execute counter, decode-hazard stalls, execute redirects and stop/halt.

Parameters:
NSTAGE, 4, pipeline depth (>=4): stage 0 fetch, 1 decode, 2..NSTAGE-3 pass-through, EX=NSTAGE-2 execute, WB=NSTAGE-1 writeback
PC_W, 32, PC width
LAT_W, 5, execute wait-time width
PC_INC, 1, sequential PC increment (word-addressed instruction memory)

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
aa_recieved  in  1  boot handshake byte received
load_done  in  1  program load complete
aa_sent  in  1  boot acknowledge transmitted
d_hazard  in  1  decode-stage operand hazard
d_stop  in  1  decode-stage instruction is stop
d_jump  in  1  decode-stage unconditional jump
d_npc  in  PC_W  decode-computed jump target
ex_wait  in  LAT_W  extra cycles the EX instruction needs
ex_uart_busy  in  1  EX UART transfer in progress
ex_redirect  in  1  taken branch/jr, valid on EX completion cycle
ex_target  in  PC_W  redirect target
mode  out  2  MODE_IDLE/LOAD/RUN/HALT
pc  out  PC_W  fetch PC
upd  out  NSTAGE-1  bit i: load enable of register between stage i and i+1
vld  out  NSTAGE  per-stage valid
flush  out  NSTAGE  per-stage kill, one cycle
e_start  out  1  one-cycle pulse when a valid instruction enters EX
ex_done  out  1  EX completes this cycle
halted  out  1  stop retired

Behaviour:
- Reset: mode=IDLE, pc=0, vld=0, flush=0, e_start=0, halted=0, lat_cnt=0, stop_seen=0. upd=0 whenever mode!=RUN. Reset mid-run aborts everything in one cycle.
- Mode FSM:
  - IDLE->LOAD on aa_recieved.
  - LOAD->RUN when load_done&&aa_sent are high in the same cycle.
  - RUN->HALT on the cycle a stop instruction is valid in WB; halted=1.
  - HALT is sticky until reset.
- On RUN entry: vld[0]=1, pc=0.
- Stall chain (combinational):
  - stall[WB]=0.
  - stall[EX]=vld[EX]&&!ex_done.
  - stall[i]=vld[i+1]&&stall[i+1] for i<EX; additionally stall[1]|=vld[1]&&d_hazard.
- Advance and valid update:
  - upd[i]=run&&!stall[i+1].
  - vld[i+1]<=stall[i+1] ? vld[i+1] : vld[i]&&!stall[i]&&!kill[i]. A held stage i with a free stage i+1 inserts a bubble.
- Execute latency:
  - lat_cnt clears and e_start pulses when a valid instruction loads into EX.
  - lat_cnt increments while lat_cnt<ex_wait.
  - ex_done=vld[EX]&&lat_cnt==ex_wait&&!ex_uart_busy. ex_wait=0 means single-cycle.
  - UART busy extends completion indefinitely.
- PC update, when !stall[0], priority highest first:
  - ex_done&&ex_redirect: pc<=ex_target; kill/flush stages 0..EX-1.
  - vld[1]&&d_jump&&!stall[1]: pc<=d_npc; kill/flush stage 0.
  - otherwise pc<=pc+PC_INC, modulo 2^PC_W.
  - A redirect overrides both stall and d_jump.
- Stop:
  - When a valid d_stop advances out of decode, set stop_seen: fetch is frozen (vld[0]<=0, pc held).
  - A per-stage stop tag travels with the instruction.
  - A redirect that flushes the stop clears stop_seen and resumes fetch at ex_target.
- Simultaneous d_hazard and redirect: the redirect wins and decode is flushed.

Optional Feature:
PIPE_CTRL_PERF_EN: adds outputs cyc_cnt, ret_cnt and stall_cnt (32 bits each, wrapping), all cleared on reset.
- cyc_cnt counts RUN cycles.
- ret_cnt counts valid WB instructions.
- stall_cnt counts cycles with stall[0]=1.
Without the macro these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared constant package holds the mode enum (MODE_IDLE=0, MODE_LOAD=1, MODE_RUN=2, MODE_HALT=3) and the EX/WB index functions of NSTAGE.
- One sub-module, pipe_lat_counter: lat_cnt, e_start and ex_done generation.

Test Plan:
- Boot: aa_recieved pulse -> mode=1; load_done=aa_sent=1 -> mode=2 next cycle, pc=0, vld=4'b0001.
- NSTAGE=4, ex_wait=0, no hazards: pc 0,1,2,…; instruction at pc0 in WB 3 cycles after RUN entry; then one valid WB per cycle.
- ex_wait=3 at pc2: e_start pulses once, EX held 4 cycles, upd[0..1]=0 while held, 3 bubbles reach WB; ex_uart_busy held 2 more cycles -> 6-cycle hold.
- d_hazard high 2 cycles: pc frozen, decode held, 2 bubbles into EX, then resumes.
- ex_redirect with ex_target=0x40 while vld[0..1]=1: flush=4'b0011 for one cycle, next pc=0x40, vld[0..1] cleared; a simultaneous d_jump is ignored.
- d_stop at pc5: pc freezes at 6, vld[0]=0; stop reaches WB -> mode=3, halted=1; a separate run where a redirect flushes the stop resumes fetch at the target.
